// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: state encoding, default
// widths and the ALU opcode map understood by the board's ALU.
package uart_alu_ctrl_pkg;

    localparam int DBIT_DEF  = 8;
    localparam int OP_SZ_DEF = 6;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_B  = ST_WAIT_B,
        WAIT_OP = ST_WAIT_OP,
        EXEC    = ST_EXEC,
        SEND    = ST_SEND
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the UART FIFO handshakes and ALU operand/result wires seen by the
// sequencer; master is the sequencer, slave is the UART/ALU side.
interface uart_alu_ctrl_if #(
    parameter int DBIT  = 8,
    parameter int OP_SZ = 6
);
    logic             i_rx_empty;
    logic [DBIT-1:0]  i_r_data;
    logic             o_rd_uart;
    logic             i_tx_full;
    logic             o_wr_uart;
    logic [DBIT-1:0]  o_w_data;
    logic [DBIT-1:0]  o_alu_a;
    logic [DBIT-1:0]  o_alu_b;
    logic [OP_SZ-1:0] o_alu_op;
    logic [DBIT-1:0]  i_alu_result;
    logic             o_busy;
    logic             o_err_tick;

    modport master (
        input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        output o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op,
               o_busy, o_err_tick
    );

    modport slave (
        output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
        input  o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op,
               o_busy, o_err_tick
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Pops an (A, B, opcode) frame from the UART rx FIFO, lets the ALU settle for
// one cycle and pushes the result byte into the tx FIFO; aborts stale frames.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int OP_SZ   = OP_SZ_DEF,
    parameter int TIMEOUT = 1000000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_alu_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [DBIT-1:0]   a_r, b_r, w_data_r;
    logic [OP_SZ-1:0]  op_r;
    logic              rd_s, wr_s, err_s;
    logic              cap_a_s, cap_b_s, cap_op_s, ld_w_s;
    logic              cnt_clr_s, cnt_inc_s;
    logic              unused_s;

    // Opcode byte bits above OP_SZ are intentionally ignored.
    assign unused_s = &{1'b0, bus.i_r_data[DBIT-1:OP_SZ]};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= WAIT_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle strobes; a byte present at expiry beats the abort.
    always_comb begin
        state_nxt_s = state_r;
        rd_s        = 1'b0;
        wr_s        = 1'b0;
        err_s       = 1'b0;
        cap_a_s     = 1'b0;
        cap_b_s     = 1'b0;
        cap_op_s    = 1'b0;
        ld_w_s      = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            WAIT_A: begin
                if (!bus.i_rx_empty) begin
                    rd_s        = 1'b1;
                    cap_a_s     = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = WAIT_B;
                end else begin
                    state_nxt_s = WAIT_A;
                end
            end
            WAIT_B, WAIT_OP: begin
                if (!bus.i_rx_empty) begin
                    rd_s        = 1'b1;
                    cnt_clr_s   = 1'b1;
                    cap_b_s     = (state_r == WAIT_B);
                    cap_op_s    = (state_r == WAIT_OP);
                    state_nxt_s = (state_r == WAIT_B) ? WAIT_OP : EXEC;
                end else if (cnt_r == CNT_LAST) begin
                    err_s       = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = WAIT_A;
                end else begin
                    cnt_inc_s   = 1'b1;
                end
            end
            EXEC: begin
                ld_w_s      = 1'b1;
                state_nxt_s = SEND;
            end
            SEND: begin
                if (!bus.i_tx_full) begin
                    wr_s        = 1'b1;
                    state_nxt_s = WAIT_A;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = WAIT_A;
            end
        endcase
    end

    // Inter-byte timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand, opcode and result registers; aborted frames leave them stale.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_r      <= {DBIT{1'b0}};
            b_r      <= {DBIT{1'b0}};
            op_r     <= {OP_SZ{1'b0}};
            w_data_r <= {DBIT{1'b0}};
        end else begin
            if (cap_a_s)  a_r      <= bus.i_r_data;
            if (cap_b_s)  b_r      <= bus.i_r_data;
            if (cap_op_s) op_r     <= bus.i_r_data[OP_SZ-1:0];
            if (ld_w_s)   w_data_r <= bus.i_alu_result;
        end
    end

    // Pulses are masked during reset so a dropped frame never pops or pushes.
    assign bus.o_rd_uart  = rd_s  & ~i_reset;
    assign bus.o_wr_uart  = wr_s  & ~i_reset;
    assign bus.o_err_tick = err_s & ~i_reset;
    assign bus.o_busy     = (state_r != WAIT_A);
    assign bus.o_alu_a    = a_r;
    assign bus.o_alu_b    = b_r;
    assign bus.o_alu_op   = op_r;
    assign bus.o_w_data   = w_data_r;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: FWFT rx FIFO model, tx capture and a
// small reference ALU; expected values are hand-computed constants.
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.DBIT(8), .OP_SZ(6)) bus ();

    uart_alu_ctrl #(.DBIT(8), .OP_SZ(6), .TIMEOUT(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_SRA:  alu_f = $unsigned($signed(a) >>> b[2:0]);
            OP_SRL:  alu_f = a >> b[2:0];
            OP_NOR:  alu_f = ~(a | b);
            default: alu_f = 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int         txc[$];
    int compared = 0, mismatched = 0;
    int rd_cnt, wr_cnt, err_cnt, both_cnt, cyc_n = 0, last_rd_cyc = 0, bad;
    logic       s_rd, s_wr, s_err, s_busy;
    logic [7:0] s_a, s_b, s_wd;
    logic [5:0] s_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int i);
        tx_at = (i < txq.size()) ? txq[i] : 8'hxx;
    endfunction

    // One clock: drive FIFO head, sample just after negedge, pop at posedge.
    task automatic cyc();
        bus.i_rx_empty = (rxq.size() == 0);
        bus.i_r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
        #1;
        s_rd = bus.o_rd_uart;  s_wr = bus.o_wr_uart;  s_err = bus.o_err_tick;
        s_busy = bus.o_busy;   s_a = bus.o_alu_a;     s_b = bus.o_alu_b;
        s_op = bus.o_alu_op;   s_wd = bus.o_w_data;
        if (s_rd) begin rd_cnt++; last_rd_cyc = cyc_n; end
        if (s_wr) begin wr_cnt++; txq.push_back(s_wd); txc.push_back(cyc_n); end
        if (s_err) err_cnt++;
        if (s_rd && s_wr) both_cnt++;
        @(posedge clk);
        if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic clr();
        rd_cnt = 0; wr_cnt = 0; err_cnt = 0; both_cnt = 0;
        txq.delete(); txc.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_tx_full  = 1'b0;
        bus.i_rx_empty = 1'b1;
        bus.i_r_data   = 8'h00;
        clr();
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;
        check("rst_busy", 32'(s_busy), 32'h0);
        check("rst_a",    32'(s_a),    32'h0);
        check("rst_b",    32'(s_b),    32'h0);
        check("rst_op",   32'(s_op),   32'h0);
        check("rst_wd",   32'(s_wd),   32'h0);
        check("rst_pulses", {29'd0, s_rd, s_wr, s_err}, 32'h0);
        cyc();
        check("idle_busy", 32'(s_busy), 32'h0);

        // 1: ADD 5+3
        clr();
        rxq.push_back(8'h05); rxq.push_back(8'h03); rxq.push_back(8'h20);
        repeat (8) cyc();
        check("t1_rd_cnt", 32'(rd_cnt), 32'd3);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t1_wdata",  32'(tx_at(0)), 32'h08);
        check("t1_a",      32'(s_a),  32'h05);
        check("t1_b",      32'(s_b),  32'h03);
        check("t1_op",     32'(s_op), 32'h20);
        check("t1_busy",   32'(s_busy), 32'h0);
        check("t1_latency", (txc.size() > 0) ? 32'(txc[0] - last_rd_cyc) : 32'hFFFF, 32'd2);

        // 2: SUB F0-0F with tx full for 10 cycles
        clr();
        bus.i_tx_full = 1'b1;
        rxq.push_back(8'hF0); rxq.push_back(8'h0F); rxq.push_back(8'h22);
        repeat (4) cyc();
        bad = 0;
        repeat (10) begin
            cyc();
            if (s_wd !== 8'hE1 || s_wr !== 1'b0 || s_busy !== 1'b1) bad++;
        end
        check("t2_hold_bad", 32'(bad), 32'd0);
        check("t2_no_wr",    32'(wr_cnt), 32'd0);
        bus.i_tx_full = 1'b0;
        cyc();
        check("t2_wr",    32'(s_wr), 32'h1);
        check("t2_wdata", 32'(s_wd), 32'hE1);
        cyc();
        check("t2_idle",  32'(s_busy), 32'h0);

        // 3: lone byte times out after 16 empty cycles
        clr();
        rxq.push_back(8'h11);
        cyc();
        repeat (15) cyc();
        check("t3_no_err_early", 32'(err_cnt), 32'd0);
        check("t3_busy_waitb",   32'(s_busy),  32'h1);
        cyc();
        check("t3_err_tick", 32'(s_err), 32'h1);
        cyc();
        check("t3_idle",      32'(s_busy), 32'h0);
        check("t3_err_cnt",   32'(err_cnt), 32'd1);
        check("t3_a_stale",   32'(s_a), 32'h11);
        rxq.push_back(8'h02); rxq.push_back(8'h02); rxq.push_back(8'h20);
        repeat (6) cyc();
        check("t3_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t3_wdata",  32'(tx_at(0)), 32'h04);

        // 4: two preloaded frames back to back
        clr();
        rxq.push_back(8'h01); rxq.push_back(8'h01); rxq.push_back(8'h20);
        rxq.push_back(8'h09); rxq.push_back(8'h04); rxq.push_back(8'h22);
        repeat (12) cyc();
        check("t4_rd_cnt", 32'(rd_cnt), 32'd6);
        check("t4_wr_cnt", 32'(wr_cnt), 32'd2);
        check("t4_wdata0", 32'(tx_at(0)), 32'h02);
        check("t4_wdata1", 32'(tx_at(1)), 32'h05);
        check("t4_rd_wr_overlap", 32'(both_cnt), 32'd0);
        check("t4_rx_left", 32'(rxq.size()), 32'd0);
        check("t4_gap", (txc.size() > 1) ? 32'(txc[1] - txc[0]) : 32'hFFFF, 32'd5);

        // 5: reset in WAIT_OP with a byte waiting
        clr();
        rxq.push_back(8'h07); rxq.push_back(8'h07); rxq.push_back(8'h09);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        check("t5_rd_in_rst", 32'(s_rd), 32'h0);
        rst = 1'b0;
        cyc();
        check("t5_busy", 32'(s_busy), 32'h0);
        check("t5_a",    32'(s_a),    32'h0);
        check("t5_b",    32'(s_b),    32'h0);
        check("t5_op",   32'(s_op),   32'h0);
        check("t5_wd",   32'(s_wd),   32'h0);
        check("t5_pop_new_a", 32'(s_rd), 32'h1);
        rxq.push_back(8'h01); rxq.push_back(8'h20);
        repeat (5) cyc();
        check("t5_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t5_wdata",  32'(tx_at(0)), 32'h0A);
        check("t5_rd_cnt", 32'(rd_cnt), 32'd5);

        // 6: byte arrives exactly on the expiry cycle
        clr();
        rxq.push_back(8'h33);
        cyc();
        repeat (15) cyc();
        rxq.push_back(8'h44);
        cyc();
        check("t6_rd",  32'(s_rd),  32'h1);
        check("t6_err", 32'(s_err), 32'h0);
        rxq.push_back(8'h20);
        repeat (5) cyc();
        check("t6_err_cnt", 32'(err_cnt), 32'd0);
        check("t6_wr_cnt",  32'(wr_cnt), 32'd1);
        check("t6_wdata",   32'(tx_at(0)), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
